digit_serial_adder: RTL and testbench

- Parametrised multi-cycle adder/subtractor that processes DIGIT bits per clock with a registered carry, for WIDTH-bit operands.
- Successor to the combinational ripple full-adder chain: trades latency for area, adds subtract mode, signed overflow detection and a start/busy/done handshake.
- Sits beside the ALU datapath as the shared arithmetic unit for the multi-cycle controller.

---
 rtl/digit_serial_adder.sv | 130 +++++++++++++
 tb/tb_digit_serial_adder.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_serial_adder.sv
// Multi-cycle digit-serial adder/subtractor with start/busy/done handshake.
// Define DSA_SATURATE_EN to saturate the sum on signed overflow.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]       a_sr, b_sr;
    logic                   carry;
    logic [CW-1:0]          cnt;
    logic [DIGIT-1:0]       da, db, ds;
    logic                   dc, cmsb, ovf;
    logic [WIDTH+DIGIT-1:0] cat;
    logic [WIDTH-1:0]       sum_nx, sat;
    logic                   accept, step, last;

    // Digit adder; on the last digit its top bit is the operand MSB.
    always_comb begin
        da     = a_sr[DIGIT-1:0];
        db     = b_sr[DIGIT-1:0];
        {dc, ds} = {1'b0, da} + {1'b0, db} + {{DIGIT{1'b0}}, carry};
        cmsb   = da[DIGIT-1] ^ db[DIGIT-1] ^ ds[DIGIT-1];
        ovf    = cmsb ^ dc;
        cat    = {ds, sum} >> DIGIT;
        sum_nx = cat[WIDTH-1:0];
        sat    = {da[DIGIT-1], {(WIDTH-1){~da[DIGIT-1]}}};
        last   = (cnt == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        accept   = 1'b0;
        step     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last)
                    state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr     <= '0;
            b_sr     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sr     <= a;
            b_sr     <= sub ? ~b : b;
            carry    <= sub;
            cnt      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (step) begin
            a_sr  <= a_sr >> DIGIT;
            b_sr  <= b_sr >> DIGIT;
            carry <= dc;
            cnt   <= cnt + 1'b1;
            sum   <= sum_nx;
            if (last) begin
                cout     <= dc;
                overflow <= ovf;
`ifdef DSA_SATURATE_EN
                if (ovf)
                    sum <= sat;
`else
                if (1'b0)
                    sum <= sat;
`endif
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed self-checking bench for digit_serial_adder.
// Covers reset, add/sub, overflow, handshake and a DIGIT sweep.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy, done, cout, overflow;
    logic [15:0] sum;

    logic        sstart = 1'b0;
    logic        ssub = 1'b0;
    logic [15:0] sa = '0;
    logic [15:0] sb = '0;
    logic        busy1, done1, cout1, ovf1;
    logic        busy2, done2, cout2, ovf2;
    logic        busy16, done16, cout16, ovf16;
    logic [15:0] sum1, sum2, sum16;

    int tests = 0;
    int fails = 0;

`ifdef DSA_SATURATE_EN
    localparam logic [15:0] OVF_SUM = 16'h7FFF;
`else
    localparam logic [15:0] OVF_SUM = 16'h8000;
`endif

    always #5 clk = ~clk;

    digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .a(a), .b(b), .busy(busy), .done(done),
        .sum(sum), .cout(cout), .overflow(overflow)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(1)) d1 (
        .clk(clk), .rst(rst), .start(sstart), .sub(ssub),
        .a(sa), .b(sb), .busy(busy1), .done(done1),
        .sum(sum1), .cout(cout1), .overflow(ovf1)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(2)) d2 (
        .clk(clk), .rst(rst), .start(sstart), .sub(ssub),
        .a(sa), .b(sb), .busy(busy2), .done(done2),
        .sum(sum2), .cout(cout2), .overflow(ovf2)
    );

    digit_serial_adder #(.WIDTH(16), .DIGIT(16)) d16 (
        .clk(clk), .rst(rst), .start(sstart), .sub(ssub),
        .a(sa), .b(sb), .busy(busy16), .done(done16),
        .sum(sum16), .cout(cout16), .overflow(ovf16)
    );

    // Reference: {overflow, cout, sum} from a full-width add.
    function automatic logic [17:0] model(input logic [15:0] x,
                                          input logic [15:0] y,
                                          input logic s);
        logic [15:0] yy;
        logic [16:0] f;
        logic        o;
        logic [15:0] r;
        yy = s ? ~y : y;
        f  = {1'b0, x} + {1'b0, yy} + {16'd0, s};
        o  = (x[15] == yy[15]) && (f[15] != x[15]);
        r  = f[15:0];
`ifdef DSA_SATURATE_EN
        if (o)
            r = x[15] ? 16'h8000 : 16'h7FFF;
`endif
        return {o, f[16], r};
    endfunction

    task automatic run_op(input logic [15:0] xa, input logic [15:0] xb,
                          input logic xs, output int lat, output int bc);
        a = xa;
        b = xb;
        sub = xs;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        bc = 0;
        while (!done && lat < 20) begin
            if (busy)
                bc++;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_op(input string name, input logic [15:0] xa,
                            input logic [15:0] xb, input logic xs,
                            input logic [15:0] es, input logic ec,
                            input logic eo);
        int lat, bc;
        run_op(xa, xb, xs, lat, bc);
        tests++;
        if (lat !== 5) begin
            fails++;
            $display("FAIL %s latency got %0d want 5", name, lat);
        end
        tests++;
        if (bc !== 4) begin
            fails++;
            $display("FAIL %s busy_cycles got %0d want 4", name, bc);
        end
        tests++;
        if ({sum, cout, overflow} !== {es, ec, eo}) begin
            fails++;
            $display("FAIL %s sum/cout/ovf got %h/%b/%b want %h/%b/%b",
                     name, sum, cout, overflow, es, ec, eo);
        end
        @(posedge clk);
        #1;
        tests++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s done_pulse got done=%b busy=%b want 0/0",
                     name, done, busy);
        end
    endtask

    task automatic test_reset();
        int bad;
        #7;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, sum, cout, overflow} !== 19'd0) begin
            fails++;
            $display("FAIL reset_outputs got %b %b %h %b %b want all 0",
                     busy, done, sum, cout, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0 || done !== 1'b0)
                bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++;
            $display("FAIL idle_quiet got %0d active cycles want 0", bad);
        end
    endtask

    task automatic test_add_sub();
        check_op("add", 16'h1234, 16'h0FF1, 1'b0, 16'h2225, 1'b0, 1'b0);
        check_op("sub_borrow", 16'h0005, 16'h0007, 1'b1,
                 16'hFFFE, 1'b0, 1'b0);
        check_op("sub_noborrow", 16'h0007, 16'h0005, 1'b1,
                 16'h0002, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        check_op("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, OVF_SUM, 1'b0, 1'b1);
        check_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        check_op("ovf_sub", 16'h8000, 16'h0001, 1'b1,
                 model(16'h8000, 16'h0001, 1'b1)[15:0], 1'b1, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [14:0] pat;
        logic [15:0] s4, s9;
        a = 16'h0001;
        b = 16'h0002;
        sub = 1'b0;
        start = 1'b1;
        pat = '0;
        s4 = '0;
        s9 = '0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                a = 16'h0010;
                b = 16'h0020;
            end
            pat[i] = done;
            if (i == 4)
                s4 = sum;
            if (i == 9)
                s9 = sum;
        end
        start = 1'b0;
        tests++;
        if (pat !== 15'h4210) begin
            fails++;
            $display("FAIL b2b_done_pattern got %h want 4210", pat);
        end
        tests++;
        if (s4 !== 16'h0003) begin
            fails++;
            $display("FAIL b2b_first_sum got %h want 0003", s4);
        end
        tests++;
        if (s9 !== 16'h0030) begin
            fails++;
            $display("FAIL b2b_second_sum got %h want 0030", s9);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_start_in_run();
        int lat;
        a = 16'h1111;
        b = 16'h2222;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        @(posedge clk);
        #1;
        lat++;
        a = 16'hAAAA;
        b = 16'h5555;
        sub = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        while (!done && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        tests++;
        if (lat !== 5 || sum !== 16'h3333) begin
            fails++;
            $display("FAIL start_in_run got lat=%0d sum=%h want 5/3333",
                     lat, sum);
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL start_in_run_queue got busy=%b done=%b want 0/0",
                     busy, done);
        end
    endtask

    task automatic test_reset_mid_run();
        int seen;
        a = 16'h1234;
        b = 16'h1111;
        sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy, done, sum, cout, overflow} !== 19'd0) begin
            fails++;
            $display("FAIL reset_mid_run got %b %b %h %b %b want all 0",
                     busy, done, sum, cout, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy)
                seen++;
        end
        tests++;
        if (seen !== 0 || sum !== 16'h0000) begin
            fails++;
            $display("FAIL reset_discard got active=%0d sum=%h want 0/0000",
                     seen, sum);
        end
    endtask

    task automatic test_sweep();
        logic [17:0] exp;
        int l1, l2, l16;
        for (int v = 0; v < 4; v++) begin
            sa = 16'($urandom);
            sb = 16'($urandom);
            ssub = v[0];
            exp = model(sa, sb, ssub);
            sstart = 1'b1;
            @(posedge clk);
            #1;
            sstart = 1'b0;
            l1 = 0;
            l2 = 0;
            l16 = 0;
            for (int c = 1; c <= 20; c++) begin
                if (done1 && l1 == 0)
                    l1 = c;
                if (done2 && l2 == 0)
                    l2 = c;
                if (done16 && l16 == 0)
                    l16 = c;
                @(posedge clk);
                #1;
            end
            tests++;
            if (l1 !== 17 || l2 !== 9 || l16 !== 2) begin
                fails++;
                $display("FAIL sweep_latency got %0d/%0d/%0d want 17/9/2",
                         l1, l2, l16);
            end
            tests++;
            if ({ovf1, cout1, sum1} !== exp) begin
                fails++;
                $display("FAIL sweep_d1 got %h want %h",
                         {ovf1, cout1, sum1}, exp);
            end
            tests++;
            if ({ovf2, cout2, sum2} !== exp) begin
                fails++;
                $display("FAIL sweep_d2 got %h want %h",
                         {ovf2, cout2, sum2}, exp);
            end
            tests++;
            if ({ovf16, cout16, sum16} !== exp) begin
                fails++;
                $display("FAIL sweep_d16 got %h want %h",
                         {ovf16, cout16, sum16}, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_overflow();
        test_back_to_back();
        test_start_in_run();
        test_reset_mid_run();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
